// File: rtl/trace_capture_buffer.sv
// Circular retire-trace buffer with arm / PC-match trigger / stop, drained oldest-first.
// Latency: records land one cycle after trace_valid; readout data is a combinational read of the buffer.
// Backpressure: rd_* holds while rd_ready is low; capture itself is never stalled (oldest records are overwritten).
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   trace_*                  retire record input (valid, pc, instr, rd, wb_data, reg_write)
//   arm, stop                control pulses: clear+start capture / end capture
//   trig_en, trig_pc         PC-match trigger enable and compare value
//   rd_valid/rd_ready, rd_*  oldest-first readout port, active only in DONE
//   state, count             FSM state (0 IDLE,1 ARMED,2 POST,3 DONE) and records captured
//   wrapped, triggered       sticky status since the last arm
module trace_capture_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_valid,
    input  logic [XLEN-1:0]          trace_pc,
    input  logic [31:0]              trace_instr,
    input  logic [4:0]               trace_rd,
    input  logic [XLEN-1:0]          trace_wb_data,
    input  logic                     trace_reg_write,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [4:0]               rd_rd,
    output logic [XLEN-1:0]          rd_wb_data,
    output logic                     rd_reg_write,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped,
    output logic                     triggered
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] wb_data;
        logic            reg_write;
    } rec_t;

    rec_t            mem [DEPTH];
    rec_t            wr_rec;
    rec_t            rd_rec;

    state_t          cur_state;
    state_t          nxt_state;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   remaining;
    logic [CW-1:0]   post_cnt;

    logic            capturing;
    logic            capture;
    logic            pc_match;
    logic            trig_hit;
    logic            post_last;
    logic            count_full;
    logic            enter_done;
    logic            rd_fire;
    logic [AW-1:0]   wr_ptr_next;
    logic [CW-1:0]   count_next;

    // ------------------------------------------------------------------
    // Capture qualification. arm wins over everything, so a record that
    // coincides with arm is dropped.
    // ------------------------------------------------------------------
    assign capturing  = (cur_state == S_ARMED) || (cur_state == S_POST);
    assign capture    = !arm && capturing && trace_valid;
    assign pc_match   = trig_en && trace_valid && (trace_pc == trig_pc);
    assign trig_hit   = !arm && (cur_state == S_ARMED) && pc_match;
    assign post_last  = (post_cnt + CW'(1)) == CW'(POST_TRIG);
    assign count_full = (count == CW'(DEPTH));

    always_comb begin
        wr_ptr_next = wr_ptr;
        count_next  = count;
        if (capture) begin
            wr_ptr_next = wr_ptr + AW'(1);
            count_next  = count_full ? count : count + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (arm) begin
            nxt_state = S_ARMED;
        end else begin
            case (cur_state)
                S_ARMED: begin
                    // stop takes precedence, but the trigger record is still
                    // captured and flagged in the datapath below.
                    if (stop) begin
                        nxt_state = S_DONE;
                    end else if (trig_hit) begin
                        nxt_state = (POST_TRIG == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (stop || (capture && post_last)) begin
                        nxt_state = S_DONE;
                    end
                end
                default: nxt_state = cur_state;
            endcase
        end
    end

    assign enter_done = (nxt_state == S_DONE) && (cur_state != S_DONE);
    assign rd_valid   = (cur_state == S_DONE) && (remaining != '0);
    assign rd_fire    = rd_valid && rd_ready;

    // ------------------------------------------------------------------
    // Pointers, counters and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            post_cnt  <= '0;
            wrapped   <= 1'b0;
            triggered <= 1'b0;
        end else if (arm) begin
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            post_cnt  <= '0;
            wrapped   <= 1'b0;
            triggered <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr_next;
                count  <= count_next;
                if (count_full) begin
                    wrapped <= 1'b1;
                end
                if (trig_hit) begin
                    triggered <= 1'b1;
                    post_cnt  <= '0;
                end else if (cur_state == S_POST) begin
                    post_cnt <= post_cnt + CW'(1);
                end
            end
            // Oldest record sits count_next slots behind the write pointer;
            // a full buffer truncates to wr_ptr_next itself.
            if (enter_done) begin
                rd_ptr    <= wr_ptr_next - AW'(count_next);
                remaining <= count_next;
            end else if (rd_fire) begin
                rd_ptr    <= rd_ptr + AW'(1);
                remaining <= remaining - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Record storage (no reset: contents are only meaningful below count)
    // ------------------------------------------------------------------
    always_comb begin
        wr_rec.pc        = trace_pc;
        wr_rec.instr     = trace_instr;
        wr_rec.rd        = trace_rd;
        wr_rec.wb_data   = trace_wb_data;
        wr_rec.reg_write = trace_reg_write;
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    assign rd_rec       = mem[rd_ptr];
    assign rd_pc        = rd_rec.pc;
    assign rd_instr     = rd_rec.instr;
    assign rd_rd        = rd_rec.rd;
    assign rd_wb_data   = rd_rec.wb_data;
    assign rd_reg_write = rd_rec.reg_write;
    assign state        = cur_state;

endmodule
